alarm_trigger: RTL and testbench
================================

# alarm_trigger

Downstream consumer of the alarm-setting stage. Compares the live time of day against the stored alarm time, both as BCD-style digits. On a match at second 00 it drives the buzzer and runs the ring, snooze and stop behaviour. Its outputs feed the buzzer pin and the status LEDs.

## Interface
- `RING_SECS`, 60: ring duration in seconds before auto-stop
- `SNOOZE_SECS`, 300: snooze interval in seconds
- `MAX_SNOOZE`, 3: maximum snoozes per alarm event
- `clk` input 1: system clock
- `rst` input 1: reset, asynchronous, active-low
- `tick_1hz` input 1: one-`clk`-wide pulse, once per second
- `alarm_en` input 1: alarm armed (level)
- `H1` input 2, `H2` input 4, `M1` input 3, `M2` input 4: current hour/minute digits
- `S1` input 3, `S2` input 4: current second digits
- `AH1` input 2, `AH2` input 4, `AM1` input 3, `AM2` input 4: alarm hour/minute digits
- `stop` input 1: one-cycle pulse, dismiss alarm
- `snooze` input 1: one-cycle pulse, request snooze
- `ringing` output 1: state is RING
- `snoozing` output 1: state is SNOOZE
- `buzzer` output 1: buzzer drive, 1 s on / 1 s off while ringing

## Operation
- `match` is combinational: all four H/M digit pairs equal, and `S1`==0 and `S2`==0.
- `match_q` is `match` registered.
- `trig` = `match` & !`match_q` & `alarm_en`. It fires once per match occurrence.
- States: IDLE, RING, SNOOZE.
- Counters: `sec_cnt` counts seconds within RING or SNOOZE. `snz_num` counts snoozes taken.
- IDLE:
  - `trig` → RING; clear `sec_cnt`, clear `snz_num`, set `phase`=1.
  - `stop` and `snooze` are ignored.
- RING:
  - On each `tick_1hz`: `phase` toggles and `sec_cnt` increments.
  - Tick with `sec_cnt`==RING_SECS-1 → IDLE (timeout).
  - `snooze` with `snz_num`<MAX_SNOOZE → SNOOZE; clear `sec_cnt`, increment `snz_num`.
  - `snooze` with `snz_num`==MAX_SNOOZE is ignored; ringing continues.
- SNOOZE:
  - `sec_cnt` increments on each tick.
  - Tick with `sec_cnt`==SNOOZE_SECS-1 → RING; clear `sec_cnt`, set `phase`=1.
- Priority within one cycle, highest first: `alarm_en`=0 (→IDLE from any state), then `stop` (→IDLE), then `snooze`, then tick-driven timeout.
- `buzzer` = `phase` in RING, 0 elsewhere.
- A `trig` while in RING or SNOOZE is ignored.
- Changing the alarm digits mid-ring has no effect on state.

## Timing
- Reset values: state IDLE; `ringing`, `snoozing`, `buzzer`, `sec_cnt`, `snz_num`, `phase` all 0; `match_q`=1.
  - `match_q`=1 means that releasing reset during a matching second does not fire.
- All outputs are registered from state.
- `match` first true in cycle N → `ringing`=1, `buzzer`=1 in cycle N+1.
- `stop` or `snooze` in cycle N → outputs update in cycle N+1.
- A tick in the same cycle as `snooze` in RING: the snooze wins, and `sec_cnt` restarts at 0 in SNOOZE.
- The timeout tick is counted inclusive. RING lasts exactly RING_SECS ticks, then `ringing` falls the cycle after the RING_SECS-th tick.
- Widths:
  - `sec_cnt` is $clog2(max(RING_SECS,SNOOZE_SECS)) bits, wrap-free.
  - `snz_num` is $clog2(MAX_SNOOZE+1) bits and saturates.
- Asserting reset mid-RING drops all outputs asynchronously.

## Structure
- Shared package `alarm_pkg` holds:
  - The state enum: IDLE=2'b00, RING=2'b01, SNOOZE=2'b10.
  - Digit width localparams, shared with the alarm-setting and timekeeping stages.
- One sub-module, `alarm_tick_timer`:
  - Tick-qualified counter with synchronous clear.
  - Terminal-count compare against a runtime limit.
  - Outputs a `done` pulse.
  - Instanced once; RING_SECS or SNOOZE_SECS is muxed in as the limit by state.
- The FSM, match logic and edge detector live in the top.

## Test plan
Bench parameters: RING_SECS=5, SNOOZE_SECS=3, MAX_SNOOZE=2; `tick_1hz` every 10 clk.
- **Trigger:** alarm 07:30, `alarm_en`=1, time steps 07:29:59→07:30:00 → `ringing`=1 next cycle, `buzzer` toggles each tick. After 5 ticks: `ringing`=0, `buzzer`=0.
- **No re-trigger:** `stop` pulse 2 cycles after trigger, time still 07:30:00 → IDLE, no re-trigger. Time 07:30:01→07:31:00 → no trigger.
- **Snooze cycle:** `snooze` during RING → `snoozing`=1 for 3 ticks, then `ringing`=1 again. Repeat → second snooze accepted. Third `snooze` ignored (`ringing` stays 1).
- **Priorities:** `stop` and `snooze` in the same cycle → IDLE. `alarm_en` dropped during SNOOZE → IDLE next cycle.
- **Reset during match:** hold `rst`=0, set time = alarm time, release `rst` → no ring. Next-day match → rings.
- **Reset mid-ring:** assert `rst` mid-RING → outputs 0 immediately, async, without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm path: FSM state encoding, clock digit widths
// and a counter-width helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10
  } alarm_state_e;

  // BCD-style digit widths, shared with the timekeeping and alarm-setting stages
  localparam int H1_W = 2;
  localparam int H2_W = 4;
  localparam int M1_W = 3;
  localparam int M2_W = 4;
  localparam int S1_W = 3;
  localparam int S2_W = 4;

  // Width of a counter that must reach max(a,b)-1 without wrapping (min 1 bit)
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Seconds counter advanced by the 1 Hz tick. Synchronous clear has priority;
// done pulses on the tick that reaches the terminal count (inclusive).
module alarm_tick_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = tick & (cnt == term);

  // Count ticks; restart on clear or when the terminal count is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm ring/snooze controller. Fires on the first clock of a matching HH:MM:00
// and drives the buzzer until stopped, snoozed or timed out.
//
//   state  | meaning
//   IDLE   | armed or disarmed, waiting for a fresh match
//   RING   | buzzer toggles each second, RING_SECS until auto-stop
//   SNOOZE | silent for SNOOZE_SECS, then back to RING
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            alarm_en,
  input  logic [H1_W-1:0] H1,
  input  logic [H2_W-1:0] H2,
  input  logic [M1_W-1:0] M1,
  input  logic [M2_W-1:0] M2,
  input  logic [S1_W-1:0] S1,
  input  logic [S2_W-1:0] S2,
  input  logic [H1_W-1:0] AH1,
  input  logic [H2_W-1:0] AH2,
  input  logic [M1_W-1:0] AM1,
  input  logic [M2_W-1:0] AM2,
  input  logic            stop,
  input  logic            snooze,
  output logic            ringing,
  output logic            snoozing,
  output logic            buzzer
);

  localparam int CW = cnt_width(RING_SECS, SNOOZE_SECS);
  localparam int SW = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
  localparam logic [CW-1:0] RING_TERM   = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_TERM = CW'(SNOOZE_SECS - 1);
  localparam logic [SW-1:0] SNZ_MAX     = SW'(MAX_SNOOZE);

  logic [1:0]    state, state_d;
  logic          phase, phase_d;
  logic [SW-1:0] snz_num, snz_d;
  logic          match, match_q, trig;
  logic          tmr_clr, tmr_done;
  logic [CW-1:0] tmr_term;

  assign match = (H1 == AH1) && (H2 == AH2) && (M1 == AM1) && (M2 == AM2) &&
                 (S1 == '0) && (S2 == '0);

  // Rising-edge of match; reset value 1 keeps a reset release inside a
  // matching second from ringing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) match_q <= 1'b1;
    else      match_q <= match;
  end

  assign trig = match & ~match_q & alarm_en;

  assign tmr_term = (state == SNOOZE) ? SNOOZE_TERM : RING_TERM;

  alarm_tick_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (tmr_clr),
    .tick  (tick_1hz),
    .term  (tmr_term),
    .done  (tmr_done)
  );

  // Next-state: disarm, then stop, then snooze, then tick timeout
  always_comb begin
    state_d = state;
    phase_d = phase;
    snz_d   = snz_num;
    tmr_clr = 1'b0;
    if (!alarm_en) begin
      state_d = IDLE;
      phase_d = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tmr_clr = 1'b1;
          if (trig) begin
            state_d = RING;
            snz_d   = '0;
            phase_d = 1'b1;
          end
        end
        RING: begin
          if (stop) begin
            state_d = IDLE;
            phase_d = 1'b0;
            tmr_clr = 1'b1;
          end else if (snooze && (snz_num < SNZ_MAX)) begin
            state_d = SNOOZE;
            snz_d   = snz_num + SW'(1);
            phase_d = 1'b0;
            tmr_clr = 1'b1;
          end else if (tick_1hz) begin
            phase_d = ~phase;
            if (tmr_done) begin
              state_d = IDLE;
              phase_d = 1'b0;
              tmr_clr = 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
            phase_d = 1'b0;
            tmr_clr = 1'b1;
          end else if (tmr_done) begin
            state_d = RING;
            phase_d = 1'b1;
            tmr_clr = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = 1'b0;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // State, buzzer phase and snooze tally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      phase   <= 1'b0;
      snz_num <= '0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      snz_num <= snz_d;
    end
  end

  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);
  assign buzzer   = (state == RING) & phase;

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: stimulus pushes expected {ringing,
// snoozing, buzzer}; a monitor pops and compares on the falling clock edge.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       alarm_en = 1'b0;
  logic [1:0] H1 = '0, AH1 = '0;
  logic [3:0] H2 = '0, AH2 = '0;
  logic [2:0] M1 = '0, AM1 = '0;
  logic [3:0] M2 = '0, AM2 = '0;
  logic [2:0] S1 = '0;
  logic [3:0] S2 = '0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       ringing, snoozing, buzzer;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  alarm_trigger #(.RING_SECS(5), .SNOOZE_SECS(3), .MAX_SNOOZE(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .alarm_en(alarm_en),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .AH1(AH1), .AH2(AH2), .AM1(AM1), .AM2(AM2),
    .stop(stop), .snooze(snooze),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if ({ringing, snoozing, buzzer} === e.exp) n_pass++;
        else $display("FAIL %s: got ring/snz/buz=%b required %b", e.name,
                      {ringing, snoozing, buzzer}, e.exp);
      end
    end
  end

  task automatic expect_out(input string name, input logic r, input logic s, input logic b);
    exp_t e;
    e.name = name;
    e.exp  = {r, s, b};
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    H1 = 2'(h / 10); H2 = 4'(h % 10);
    M1 = 3'(m / 10); M2 = 4'(m % 10);
    S1 = 3'(s / 10); S2 = 4'(s % 10);
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  // Approach 07:30:00 from 07:29:59 so the match edge fires
  task automatic hit_alarm();
    set_time(7, 29, 59);
    step(2);
    set_time(7, 30, 0);
    step(1);
  endtask

  initial begin
    AH1 = 2'd0; AH2 = 4'd7; AM1 = 3'd3; AM2 = 4'd0;
    set_time(7, 29, 59);
    step(2);
    expect_out("reset", 0, 0, 0);
    step(1);
    rst = 1'b1;
    alarm_en = 1'b1;
    step(3);
    expect_out("idle_pre", 0, 0, 0);

    // Trigger and full ring to timeout
    hit_alarm();
    expect_out("trig", 1, 0, 1);
    step(9);
    tick_pulse(); expect_out("ring_t1", 1, 0, 0); step(9);
    tick_pulse(); expect_out("ring_t2", 1, 0, 1); step(9);
    tick_pulse(); expect_out("ring_t3", 1, 0, 0); step(9);
    tick_pulse(); expect_out("ring_t4", 1, 0, 1); step(9);
    expect_out("ring_pre_timeout", 1, 0, 1);
    tick_pulse(); expect_out("ring_timeout", 0, 0, 0);
    step(5);
    expect_out("no_retrig_after_timeout", 0, 0, 0);

    // Stop, then no re-trigger while still matching or on non-zero seconds
    hit_alarm();
    expect_out("trig2", 1, 0, 1);
    step(1);
    stop = 1'b1; step(1); stop = 1'b0;
    expect_out("stop", 0, 0, 0);
    step(5);
    expect_out("no_retrig_same_sec", 0, 0, 0);
    set_time(7, 30, 1); step(2);
    set_time(7, 31, 0); step(2);
    expect_out("no_trig_other_min", 0, 0, 0);

    // Digits changed mid-ring leave the state alone
    hit_alarm();
    expect_out("trig3", 1, 0, 1);
    AM2 = 4'd5; step(2);
    expect_out("alarm_change_midring", 1, 0, 1);
    AM2 = 4'd0;
    stop = 1'b1; step(1); stop = 1'b0;
    expect_out("stop3", 0, 0, 0);

    // Snooze cycles
    hit_alarm();
    expect_out("trig4", 1, 0, 1);
    step(9);
    tick_pulse(); expect_out("s_ring_t1", 1, 0, 0); step(9);
    snooze = 1'b1; step(1); snooze = 1'b0;
    expect_out("snooze1", 0, 1, 0);
    step(8);
    tick_pulse(); expect_out("snz1_t1", 0, 1, 0); step(9);
    tick_pulse(); expect_out("snz1_t2", 0, 1, 0); step(9);
    tick_pulse(); expect_out("snz1_end", 1, 0, 1); step(9);
    // Snooze with a simultaneous tick: snooze wins and the count restarts
    tick_1hz = 1'b1; snooze = 1'b1; step(1); tick_1hz = 1'b0; snooze = 1'b0;
    expect_out("snooze2_with_tick", 0, 1, 0);
    step(9);
    tick_pulse(); expect_out("snz2_t1", 0, 1, 0); step(9);
    tick_pulse(); expect_out("snz2_t2", 0, 1, 0); step(9);
    tick_pulse(); expect_out("snz2_end", 1, 0, 1); step(9);
    snooze = 1'b1; step(1); snooze = 1'b0;
    expect_out("snooze3_ignored", 1, 0, 1);
    step(8);
    tick_pulse(); expect_out("ring_after_max", 1, 0, 0); step(9);
    stop = 1'b1; step(1); stop = 1'b0;
    expect_out("stop_after_snooze", 0, 0, 0);

    // Priorities
    hit_alarm();
    expect_out("trig5", 1, 0, 1);
    stop = 1'b1; snooze = 1'b1; step(1); stop = 1'b0; snooze = 1'b0;
    expect_out("stop_beats_snooze", 0, 0, 0);
    hit_alarm();
    expect_out("trig6", 1, 0, 1);
    snooze = 1'b1; step(1); snooze = 1'b0;
    expect_out("snooze_count_cleared", 0, 1, 0);
    alarm_en = 1'b0; step(1);
    expect_out("disarm_in_snooze", 0, 0, 0);
    hit_alarm();
    expect_out("disarmed_no_trig", 0, 0, 0);
    alarm_en = 1'b1; step(2);
    expect_out("arm_mid_match_no_trig", 0, 0, 0);

    // Reset held across a matching second
    rst = 1'b0; step(2);
    set_time(7, 30, 0); step(2);
    rst = 1'b1; step(3);
    expect_out("reset_release_in_match", 0, 0, 0);
    set_time(7, 30, 1); step(2);
    set_time(7, 30, 0); step(1);
    expect_out("next_day_trig", 1, 0, 1);

    // Asynchronous reset mid-ring: checked before any further rising edge
    step(9);
    tick_pulse(); expect_out("pre_reset_ring", 1, 0, 0);
    step(3);
    rst = 1'b0;
    expect_out("async_reset", 0, 0, 0);
    step(2);
    rst = 1'b1; step(3);
    expect_out("after_reset_release", 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
